// File: rtl/axis_stream_comparator.sv
// Paired AXI-Stream comparator: consumes a DUT stream and a golden stream in lockstep and records mismatches.
// Optional idle timeout is enabled by defining AXIS_COMPARATOR_TIMEOUT_EN.
//
// state    | meaning
// SKIPPING | consuming leading beats without comparing
// CHECKING | comparing data and last on every paired beat
// HALTED   | stopped on error or timeout, readies low until reset
// DONE     | both streams delivered last on the same beat
module axis_stream_comparator #(
  parameter int DATA_WIDTH    = 10,
  parameter int SKIP          = 0,
  parameter int CNT_WIDTH     = 32,
  parameter int STOP_ON_ERROR = 0
`ifdef AXIS_COMPARATOR_TIMEOUT_EN
  , parameter int TIMEOUT     = 1024
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dut_valid,
  input  logic [DATA_WIDTH-1:0] dut_data,
  input  logic                  dut_last,
  output logic                  dut_ready,
  input  logic                  ref_valid,
  input  logic [DATA_WIDTH-1:0] ref_data,
  input  logic                  ref_last,
  output logic                  ref_ready,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  first_err_index,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic [DATA_WIDTH-1:0] first_err_exp
`ifdef AXIS_COMPARATOR_TIMEOUT_EN
  , output logic                timeout
`endif
);

  typedef enum logic [1:0] {ST_SKIPPING, ST_CHECKING, ST_HALTED, ST_DONE} state_t;

  localparam state_t               ST_INIT   = (SKIP > 0) ? ST_SKIPPING : ST_CHECKING;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SKIP_LOAD = CNT_WIDTH'(SKIP);

  state_t               state, state_nxt;
  logic                 armed;
  logic                 active;
  logic                 fire;
  logic                 check_beat;
  logic                 beat_mis;
  logic                 both_last;
  logic                 timeout_hit;
  logic [CNT_WIDTH-1:0] skip_left;

  // armed holds off consumption for the first cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  assign active     = (state == ST_SKIPPING) || (state == ST_CHECKING);
  assign fire       = armed && active && dut_valid && ref_valid;
  assign check_beat = fire && (state == ST_CHECKING);
  assign beat_mis   = check_beat && ((dut_data != ref_data) || (dut_last != ref_last));
  assign both_last  = check_beat && dut_last && ref_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SKIPPING: begin
        if (timeout_hit)                      state_nxt = ST_HALTED;
        else if (fire && skip_left == CNT_ONE) state_nxt = ST_CHECKING;
      end
      ST_CHECKING: begin
        if (timeout_hit)                              state_nxt = ST_HALTED;
        else if (beat_mis && (STOP_ON_ERROR != 0))    state_nxt = ST_HALTED;
        else if (both_last)                           state_nxt = ST_DONE;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    dut_ready = 1'b0;
    ref_ready = 1'b0;
    if (armed && active) begin
      dut_ready = ref_valid;
      ref_ready = dut_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skip_left <= SKIP_LOAD;
    end else if (fire && state == ST_SKIPPING) begin
      skip_left <= skip_left - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done            <= 1'b0;
      error           <= 1'b0;
      mismatch_count  <= '0;
      beat_count      <= '0;
      first_err_index <= '0;
      first_err_got   <= '0;
      first_err_exp   <= '0;
    end else begin
      done <= (state_nxt == ST_DONE);
      if (beat_mis || timeout_hit) error <= 1'b1;
      if (fire && beat_count != CNT_MAX) beat_count <= beat_count + CNT_ONE;
      if (beat_mis && mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_ONE;
      // a saturating count never returns to zero, so zero means nothing captured yet
      if (beat_mis && mismatch_count == '0) begin
        first_err_index <= beat_count;
        first_err_got   <= dut_data;
        first_err_exp   <= ref_data;
      end
    end
  end

`ifdef AXIS_COMPARATOR_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT);

  logic [CNT_WIDTH-1:0] idle_left;

  // idle_left reaching one on an idle cycle marks TIMEOUT consecutive idle cycles
  assign timeout_hit = active && !fire && (idle_left == CNT_ONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_left <= TIMEOUT_LOAD;
      timeout   <= 1'b0;
    end else begin
      if (fire)                            idle_left <= TIMEOUT_LOAD;
      else if (active && idle_left != '0)  idle_left <= idle_left - CNT_ONE;
      if (timeout_hit) timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axis_stream_comparator.sv
// Randomized bench for axis_stream_comparator: three parameterisations share one stimulus and are
// checked against a beat-list reference model. Timeout instance only when AXIS_COMPARATOR_TIMEOUT_EN is defined.
module tb_axis_stream_comparator;
  localparam int DW = 10;
  localparam int CW = 32;
  localparam int NI = 3;

  typedef struct {
    bit              done, err, term;
    longint unsigned mc, bc, fi, fg, fe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          dut_valid, ref_valid, dut_last, ref_last;
  logic [DW-1:0] dut_data, ref_data;

  logic          dr [NI];
  logic          rr [NI];
  logic          done_o [NI];
  logic          err_o [NI];
  logic [CW-1:0] mc_o [NI];
  logic [CW-1:0] bc_o [NI];
  logic [CW-1:0] fi_o [NI];
  logic [DW-1:0] fg_o [NI];
  logic [DW-1:0] fe_o [NI];

  int skips [NI] = '{0, 2, 0};
  int stops [NI] = '{0, 0, 1};

  logic [DW-1:0] sd [32];
  logic [DW-1:0] rd [32];
  bit            sl [32];
  bit            rl [32];
  int            n;

  int passed = 0;
  int total  = 0;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    axis_stream_comparator #(
      .DATA_WIDTH   (DW),
      .SKIP         ((g == 1) ? 2 : 0),
      .CNT_WIDTH    (CW),
      .STOP_ON_ERROR((g == 2) ? 1 : 0)
`ifdef AXIS_COMPARATOR_TIMEOUT_EN
      , .TIMEOUT    (1024)
`endif
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .dut_valid      (dut_valid),
      .dut_data       (dut_data),
      .dut_last       (dut_last),
      .dut_ready      (dr[g]),
      .ref_valid      (ref_valid),
      .ref_data       (ref_data),
      .ref_last       (ref_last),
      .ref_ready      (rr[g]),
      .done           (done_o[g]),
      .error          (err_o[g]),
      .mismatch_count (mc_o[g]),
      .beat_count     (bc_o[g]),
      .first_err_index(fi_o[g]),
      .first_err_got  (fg_o[g]),
      .first_err_exp  (fe_o[g])
`ifdef AXIS_COMPARATOR_TIMEOUT_EN
      , .timeout      ()
`endif
    );
  end

`ifdef AXIS_COMPARATOR_TIMEOUT_EN
  logic          t_zero = 1'b0;
  logic [DW-1:0] t_zd = '0;
  logic          t_dr, t_rr, t_done, t_err, t_to;
  logic [CW-1:0] t_mc, t_bc, t_fi;
  logic [DW-1:0] t_fg, t_fe;
  axis_stream_comparator #(.DATA_WIDTH(DW), .SKIP(0), .CNT_WIDTH(CW), .STOP_ON_ERROR(0), .TIMEOUT(16)) u_to (
    .clk(clk), .rst(rst),
    .dut_valid(t_zero), .dut_data(t_zd), .dut_last(t_zero), .dut_ready(t_dr),
    .ref_valid(t_zero), .ref_data(t_zd), .ref_last(t_zero), .ref_ready(t_rr),
    .done(t_done), .error(t_err), .mismatch_count(t_mc), .beat_count(t_bc),
    .first_err_index(t_fi), .first_err_got(t_fg), .first_err_exp(t_fe), .timeout(t_to)
  );
`endif

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: walk the beat list in order, stopping where the comparator would stop consuming.
  task automatic model(input int skip, input int stop, output exp_t e);
    e = '{default: 0};
    for (int i = 0; i < n; i++) begin
      e.bc++;
      if (i < skip) continue;
      if (sd[i] != rd[i] || sl[i] != rl[i]) begin
        if (e.mc == 0) begin
          e.fi = i; e.fg = sd[i]; e.fe = rd[i];
        end
        e.mc++;
        e.err = 1;
        if (stop != 0) begin e.term = 1; break; end
      end
      if (sl[i] && rl[i]) begin e.done = 1; e.term = 1; break; end
    end
  endtask

  task automatic do_reset();
    dut_valid = 0; ref_valid = 0; rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    dut_valid = 1; ref_valid = 1; dut_data = 10'h0AA; ref_data = 10'h055;
    dut_last = 0; ref_last = 0;
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("rel_dready_i%0d", i), dr[i], 0);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rel_beats_i%0d", i), bc_o[i], 0);
      check($sformatf("rel_err_i%0d", i), err_o[i], 0);
    end
    dut_valid = 0; ref_valid = 0;
  endtask

  task automatic run_stream();
    int k = 0;
    int cyc = 0;
    bit hd = 0, hr = 0, dv, rv;
    while (k < n && cyc < 2000) begin
      dv = hd || ($urandom_range(0, 3) != 0);
      rv = hr || ($urandom_range(0, 3) != 0);
      dut_valid = dv; ref_valid = rv;
      dut_data = sd[k]; dut_last = sl[k]; ref_data = rd[k]; ref_last = rl[k];
      @(posedge clk);
      if (dv && rv) begin k++; hd = 0; hr = 0; end
      else begin hd = dv; hr = rv; end
      @(negedge clk);
      cyc++;
    end
    if (k < n) check("stream_drain", k, n);
    dut_valid = 0; ref_valid = 0;
    repeat (2) @(negedge clk);
  endtask

  // Leaves both valids high with no clock edge taken; caller resets next.
  task automatic check_all(input int sc);
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      model(skips[i], stops[i], e);
      check($sformatf("s%0d_i%0d_done", sc, i), done_o[i], e.done);
      check($sformatf("s%0d_i%0d_err", sc, i), err_o[i], e.err);
      check($sformatf("s%0d_i%0d_mcnt", sc, i), mc_o[i], e.mc);
      check($sformatf("s%0d_i%0d_bcnt", sc, i), bc_o[i], e.bc);
      check($sformatf("s%0d_i%0d_fidx", sc, i), fi_o[i], e.fi);
      check($sformatf("s%0d_i%0d_fgot", sc, i), fg_o[i], e.fg);
      check($sformatf("s%0d_i%0d_fexp", sc, i), fe_o[i], e.fe);
    end
    dut_valid = 1; ref_valid = 1;
    #1;
    for (int i = 0; i < NI; i++) begin
      model(skips[i], stops[i], e);
      check($sformatf("s%0d_i%0d_dready", sc, i), dr[i], !e.term);
      check($sformatf("s%0d_i%0d_rready", sc, i), rr[i], !e.term);
    end
  endtask

  task automatic fill_equal(input int len);
    n = len;
    for (int i = 0; i < len; i++) begin
      sd[i] = DW'($urandom); rd[i] = sd[i]; sl[i] = 0; rl[i] = 0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

`ifdef AXIS_COMPARATOR_TIMEOUT_EN
    repeat (20) @(negedge clk);
    check("to_flag", t_to, 1);
    check("to_err", t_err, 1);
    check("to_mcnt", t_mc, 0);
    check("to_bcnt", t_bc, 0);
    do_reset();
`endif

    // six identical beats, last on the final one
    fill_equal(6); sl[5] = 1; rl[5] = 1;
    run_stream(); check_all(0); do_reset();

    // single data mismatch at index 3
    fill_equal(8); sd[3] = 10'h155; rd[3] = 10'h154; sl[7] = 1; rl[7] = 1;
    run_stream(); check_all(1); do_reset();

    // early mismatch at index 1
    fill_equal(5); sd[1] = 10'h001; rd[1] = 10'h002; sl[4] = 1; rl[4] = 1;
    run_stream(); check_all(2); do_reset();

    // last disagreement: dut ends at 4, ref at 5
    fill_equal(7); sl[4] = 1; sl[5] = 1; rl[5] = 1;
    run_stream(); check_all(3); do_reset();

    // golden stream stalls while DUT stream waits
    dut_valid = 1; ref_valid = 0; dut_data = 10'h3FF;
    repeat (50) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("stall_i%0d_dready", i), dr[i], 0);
      check($sformatf("stall_i%0d_rready", i), rr[i], 1);
      check($sformatf("stall_i%0d_bcnt", i), bc_o[i], 0);
      check($sformatf("stall_i%0d_mcnt", i), mc_o[i], 0);
    end
    do_reset();

    for (int sc = 10; sc < 20; sc++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        sd[i] = DW'($urandom);
        rd[i] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : sd[i];
        sl[i] = ($urandom_range(0, 5) == 0);
        rl[i] = ($urandom_range(0, 5) == 0) ? 1'b1 : sl[i];
      end
      if ($urandom_range(0, 1) == 1) begin sl[n-1] = 1; rl[n-1] = 1; end
      run_stream(); check_all(sc); do_reset();
    end

    // reset asserted mid-run, between clock edges
    fill_equal(8); sd[0] = ~rd[0];
    run_stream(); check_all(30);
    #2 rst = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("mid_i%0d_dready", i), dr[i], 0);
      check($sformatf("mid_i%0d_rready", i), rr[i], 0);
      check($sformatf("mid_i%0d_err", i), err_o[i], 0);
      check($sformatf("mid_i%0d_done", i), done_o[i], 0);
      check($sformatf("mid_i%0d_bcnt", i), bc_o[i], 0);
      check($sformatf("mid_i%0d_mcnt", i), mc_o[i], 0);
      check($sformatf("mid_i%0d_fidx", i), fi_o[i], 0);
      check($sformatf("mid_i%0d_fgot", i), fg_o[i], 0);
      check($sformatf("mid_i%0d_fexp", i), fe_o[i], 0);
    end
    do_reset();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axis_stream_comparator.md
AXIS_STREAM_COMPARATOR -- requirements
Module: axis_stream_comparator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, the width in bits of both data buses.
REQ-002 SHALL have parameter SKIP, default 0, the number of leading paired beats consumed but not compared.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, the width of all counters and index outputs.
REQ-004 SHALL have parameter STOP_ON_ERROR, default 0; when 1, the block halts on the first mismatch.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have ports dut_valid (in, 1), dut_data (in, DATA_WIDTH), dut_last (in, 1) and dut_ready (out, 1), forming the stream under test.
REQ-008 SHALL have ports ref_valid (in, 1), ref_data (in, DATA_WIDTH), ref_last (in, 1) and ref_ready (out, 1), forming the golden stream.
REQ-009 SHALL have outputs done (1), error (1), mismatch_count (CNT_WIDTH) and beat_count (CNT_WIDTH).
REQ-010 SHALL have outputs first_err_index (CNT_WIDTH), first_err_got (DATA_WIDTH) and first_err_exp (DATA_WIDTH).

Function
REQ-011 SHALL implement FSM states SKIPPING, CHECKING, HALTED and DONE; the state after reset is SKIPPING if SKIP>0, otherwise CHECKING.
REQ-012 SHALL drive dut_ready = ref_valid and ref_ready = dut_valid while in SKIPPING or CHECKING, and 0 in HALTED and DONE.
- A beat is consumed only when dut_valid and ref_valid are both high.
- No beat is consumed on one stream alone.
REQ-013 SHALL increment beat_count by 1 on every consumed beat, including skipped beats, saturating at all-ones.
REQ-014 SHALL leave SKIPPING for CHECKING after exactly SKIP consumed beats, and SHALL NOT compare data or last during SKIPPING.
REQ-015 SHALL flag a mismatch on a consumed beat in CHECKING if dut_data differs from ref_data or dut_last differs from ref_last.
REQ-016 SHALL, on a mismatch, increment mismatch_count (saturating) and set error; error is sticky until reset.
REQ-017 SHALL capture first_err_index, first_err_got and first_err_exp on the first mismatch only.
- first_err_index is the beat_count value before increment.
- All three are frozen afterwards.
REQ-018 SHALL move to HALTED on a mismatch when STOP_ON_ERROR=1; HALTED is exited only by reset.
REQ-019 SHALL move to DONE on a consumed CHECKING beat with dut_last and ref_last both high, even if data mismatched and STOP_ON_ERROR=0; DONE is exited only by reset.
REQ-020 SHALL, on a simultaneous mismatch and both-last beat with STOP_ON_ERROR=1, enter HALTED, not DONE.
REQ-021 SHALL ignore last on both streams during SKIPPING; a both-last beat during SKIPPING does not end the run.
REQ-022 SHALL register all status outputs, updating them one cycle after the consuming edge; done is high exactly in DONE.

Reset
REQ-023 SHALL, on rst low, immediately clear done, error, mismatch_count, beat_count, first_err_index, first_err_got and first_err_exp to 0.
REQ-024 SHALL force dut_ready and ref_ready to 0 while rst is low, including when reset is asserted mid-run.
REQ-025 SHALL consume no beat in the first cycle after rst is released.

Configuration
REQ-026 SHALL, when macro AXIS_COMPARATOR_TIMEOUT_EN is defined, add parameter TIMEOUT (default 1024) and a sticky output timeout (1 bit, reset 0).
- An idle counter clears on every consumed beat.
- The counter increments on every SKIPPING or CHECKING cycle with no consumed beat.
- timeout is set and error is set, without touching mismatch_count, when the counter reaches TIMEOUT.
- On timeout the FSM enters HALTED regardless of STOP_ON_ERROR.
REQ-027 SHALL, without AXIS_COMPARATOR_TIMEOUT_EN, have no timeout port, no TIMEOUT parameter and no idle counter.

Verification
REQ-028 SHALL cover: SKIP=2, 6 identical beats, last on beat 6 -> done=1, error=0, beat_count=6, mismatch_count=0.
REQ-029 SHALL cover: STOP_ON_ERROR=0, beat 3 has dut 0x155 vs ref 0x154 -> error=1, mismatch_count=1, first_err_index=3, first_err_got=0x155, first_err_exp=0x154, run reaches done.
REQ-030 SHALL cover: STOP_ON_ERROR=1, mismatch on beat 1 -> HALTED, both readies 0 thereafter, beat_count frozen at 2.
REQ-031 SHALL cover: dut_last on beat 4, ref_last on beat 5 -> mismatch counted at beat 4, done on beat 5 (STOP_ON_ERROR=0).
REQ-032 SHALL cover: ref_valid held low for 50 cycles with dut_valid high -> no beats consumed, dut_ready=0, counters unchanged; rst pulsed low mid-run -> all outputs 0 within the same cycle.
REQ-033 SHALL cover, with AXIS_COMPARATOR_TIMEOUT_EN and TIMEOUT=16: 16 cycles with no pairing -> timeout=1, error=1, mismatch_count=0.
